// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcode values, FSM encoding, default widths.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_pkg;

  // Default datapath width; must match the ALU A/B/Y ports.
  localparam int DEF_DW = 32;

  // Opcode field width on the ALU Op_code port.
  localparam int OPW = 3;

  // ALU opcodes as presented on Op_code.
  localparam logic [OPW-1:0] OP_PASSA = 3'b000;  // Y = A
  localparam logic [OPW-1:0] OP_ADD   = 3'b001;  // Y = A + B
  localparam logic [OPW-1:0] OP_SUB   = 3'b010;  // Y = A - B
  localparam logic [OPW-1:0] OP_AND   = 3'b011;  // Y = A & B
  localparam logic [OPW-1:0] OP_OR    = 3'b100;  // Y = A | B
  localparam logic [OPW-1:0] OP_INC   = 3'b101;  // Y = A + 1
  localparam logic [OPW-1:0] OP_DEC   = 3'b110;  // Y = A - 1
  localparam logic [OPW-1:0] OP_PASSB = 3'b111;  // Y = B

  // Issue FSM encoding; one instruction in flight at a time.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

endpackage : alu_pkg

// File: rtl/alu_regfile.sv
// Operand register file: NREGS x DW, two async read ports, one sync write port, entry 0 reads zero.
// Latency: reads combinational; a write is visible on the read ports the cycle after it is applied.
// Backpressure: none; every write presented with we=1 is applied (writes to entry 0 are dropped).
module alu_regfile #(
  parameter int NREGS = 8,
  parameter int DW    = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] rd1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] mem [NREGS];

  // Entry 0 is never written, so it stays at its reset value of zero; reads are
  // still forced to zero so the hardwired-zero behaviour does not depend on that.
  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

  // Synchronous clear of every entry, then single-port write with entry 0 protected.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

endmodule : alu_regfile

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the external combinational ALU: reads operands, drives the ALU, writes Y back.
// Latency: IDLE(accept) -> READ -> EXEC -> WB; res_valid in the 4th cycle counting the accept cycle.
// Backpressure: instr_ready is high only in IDLE; one instruction in flight, 1 per 4 cycles.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int DW    = DEF_DW,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic           clk,
  input  logic           reset,
  // Instruction handshake
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [OPW-1:0] instr_op,
  input  logic [AW-1:0]  instr_rd,
  input  logic [AW-1:0]  instr_rs1,
  input  logic [AW-1:0]  instr_rs2,
  // Register preload
  input  logic           cfg_we,
  input  logic [AW-1:0]  cfg_addr,
  input  logic [DW-1:0]  cfg_wdata,
  // ALU interface
  output logic [OPW-1:0] alu_op,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  input  logic [DW-1:0]  alu_y,
  // Completion
  output logic           res_valid,
  output logic [AW-1:0]  res_rd,
  output logic [DW-1:0]  res_data,
  output logic           busy
);

  logic [1:0]     state;

  // Instruction fields captured at accept; the instr_* inputs are free to change afterwards.
  logic [OPW-1:0] op_q;
  logic [AW-1:0]  rd_q;
  logic [AW-1:0]  rs1_q;
  logic [AW-1:0]  rs2_q;

  // Register file hookup.
  logic [DW-1:0]  rf_rd1;
  logic [DW-1:0]  rf_rd2;
  logic           rf_we;
  logic [AW-1:0]  rf_wa;
  logic [DW-1:0]  rf_wd;

  assign instr_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  // The strobe coincides with the register write-back cycle.
  assign res_valid   = (state == ST_WB);

  // Write port mux: write-back owns the port in WB; cfg preloads are only honoured in IDLE.
  // The two sources are never active in the same state, so no arbitration is needed.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = cfg_addr;
    rf_wd = cfg_wdata;
    if (state == ST_WB) begin
      rf_we = 1'b1;
      rf_wa = res_rd;
      rf_wd = res_data;
    end else if ((state == ST_IDLE) && cfg_we) begin
      rf_we = 1'b1;
    end
  end

  alu_regfile #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs1_q),
    .rd1   (rf_rd1),
    .ra2   (rs2_q),
    .rd2   (rf_rd2),
    .we    (rf_we),
    .wa    (rf_wa),
    .wd    (rf_wd)
  );

  // Issue FSM plus the ALU input and result registers. A reset at any point drops the
  // in-flight instruction: the state returns to IDLE before WB can strobe or write.
  // alu_op/alu_a/alu_b are only loaded in READ and otherwise hold their last values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      res_rd   <= '0;
      res_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            op_q  <= instr_op;
            rd_q  <= instr_rd;
            rs1_q <= instr_rs1;
            rs2_q <= instr_rs2;
            state <= ST_READ;
          end
        end
        ST_READ: begin
          // Operands are sampled here, before any write-back of this instruction,
          // so rd == rs1/rs2 sees the old register value.
          alu_op <= op_q;
          alu_a  <= rf_rd1;
          alu_b  <= rf_rd2;
          state  <= ST_EXEC;
        end
        ST_EXEC: begin
          res_data <= alu_y;
          res_rd   <= rd_q;
          state    <= ST_WB;
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : alu_issue_ctrl

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural combinational ALU beside it.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int NREGS = 8;
  localparam int DW    = 32;
  localparam int AW    = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           instr_valid;
  logic           instr_ready;
  logic [OPW-1:0] instr_op;
  logic [AW-1:0]  instr_rd;
  logic [AW-1:0]  instr_rs1;
  logic [AW-1:0]  instr_rs2;
  logic           cfg_we;
  logic [AW-1:0]  cfg_addr;
  logic [DW-1:0]  cfg_wdata;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [DW-1:0]  alu_y;
  logic           res_valid;
  logic [AW-1:0]  res_rd;
  logic [DW-1:0]  res_data;
  logic           busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .NREGS (NREGS),
    .DW    (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_rs1   (instr_rs1),
    .instr_rs2   (instr_rs2),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_y       (alu_y),
    .res_valid   (res_valid),
    .res_rd      (res_rd),
    .res_data    (res_data),
    .busy        (busy)
  );

  // Combinational ALU standing in for the real instance.
  always_comb begin
    alu_y = alu_a;
    case (alu_op)
      OP_PASSA: alu_y = alu_a;
      OP_ADD:   alu_y = alu_a + alu_b;
      OP_SUB:   alu_y = alu_a - alu_b;
      OP_AND:   alu_y = alu_a & alu_b;
      OP_OR:    alu_y = alu_a | alu_b;
      OP_INC:   alu_y = alu_a + 32'd1;
      OP_DEC:   alu_y = alu_a - 32'd1;
      OP_PASSB: alu_y = alu_b;
      default:  alu_y = alu_a;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    tick();
    cfg_we    = 1'b0;
  endtask

  // Issue one instruction and follow it to completion. Returns the captured result,
  // the cycle index (1 = first cycle after accept) of the strobe, the number of
  // cycles instr_ready stayed low, and how many strobe cycles were seen.
  task automatic issue(input logic [OPW-1:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       output logic [DW-1:0] y, output logic [AW-1:0] yrd,
                       output int lat, output int rdy_low, output int strobes);
    int n;
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rd    = rd;
    instr_rs1   = rs1;
    instr_rs2   = rs2;
    n = 0;
    while (!instr_ready && n < 10) begin
      tick();
      n++;
    end
    tick();
    instr_valid = 1'b0;
    cfg_we      = 1'b0;
    y = 'x;
    yrd = 'x;
    lat = 0;
    rdy_low = 0;
    strobes = 0;
    n = 1;
    while (!instr_ready && n <= 8) begin
      rdy_low++;
      if (res_valid) begin
        strobes++;
        if (lat == 0) begin
          lat = n;
          y   = res_data;
          yrd = res_rd;
        end
      end
      tick();
      n++;
    end
    if (res_valid) strobes++;
  endtask

  logic [DW-1:0] y;
  logic [AW-1:0] yrd;
  int lat, rdy_low, strobes;

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr_op    = '0;
    instr_rd    = '0;
    instr_rs1   = '0;
    instr_rs2   = '0;
    cfg_we      = 1'b0;
    cfg_addr    = '0;
    cfg_wdata   = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_ready",    32'(instr_ready), 32'd1);
    chk("rst_busy",     32'(busy),        32'd0);
    chk("rst_res_vld",  32'(res_valid),   32'd0);
    chk("rst_alu_op",   32'(alu_op),      32'd0);
    chk("rst_alu_a",    alu_a,            32'd0);
    chk("rst_alu_b",    alu_b,            32'd0);
    chk("rst_res_rd",   32'(res_rd),      32'd0);
    chk("rst_res_data", res_data,         32'd0);

    // 1: R1=5, R2=3, R3 = R1 + R2
    cfg_write(3'd1, 32'd5);
    cfg_write(3'd2, 32'd3);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, y, yrd, lat, rdy_low, strobes);
    chk("t1_data",    y,              32'd8);
    chk("t1_rd",      32'(yrd),       32'd3);
    chk("t1_lat",     32'(lat),       32'd3);
    chk("t1_rdy_low", 32'(rdy_low),   32'd3);
    chk("t1_strobes", 32'(strobes),   32'd1);
    chk("t1_hold_op", 32'(alu_op),    32'(OP_ADD));
    chk("t1_hold_a",  alu_a,          32'd5);
    chk("t1_hold_b",  alu_b,          32'd3);
    issue(OP_PASSA, 3'd6, 3'd3, 3'd0, y, yrd, lat, rdy_low, strobes);
    chk("t1_r3",      y,              32'd8);

    // Other opcodes on R1=5, R2=3
    issue(OP_SUB, 3'd6, 3'd1, 3'd2, y, yrd, lat, rdy_low, strobes);
    chk("sub",   y, 32'd2);
    issue(OP_AND, 3'd6, 3'd1, 3'd2, y, yrd, lat, rdy_low, strobes);
    chk("and",   y, 32'd1);
    issue(OP_OR, 3'd6, 3'd1, 3'd2, y, yrd, lat, rdy_low, strobes);
    chk("or",    y, 32'd7);
    issue(OP_PASSB, 3'd6, 3'd1, 3'd2, y, yrd, lat, rdy_low, strobes);
    chk("passb", y, 32'd3);

    // 3: write to R0 strobes but is dropped
    issue(OP_ADD, 3'd0, 3'd1, 3'd2, y, yrd, lat, rdy_low, strobes);
    chk("t3_data",    y,            32'd8);
    chk("t3_strobes", 32'(strobes), 32'd1);
    issue(OP_PASSA, 3'd6, 3'd0, 3'd0, y, yrd, lat, rdy_low, strobes);
    chk("t3_r0",      y,            32'd0);
    cfg_write(3'd0, 32'h0000_0055);
    issue(OP_PASSA, 3'd6, 3'd0, 3'd0, y, yrd, lat, rdy_low, strobes);
    chk("t3_r0_cfg",  y,            32'd0);

    // 2: modulo wrap
    cfg_write(3'd1, 32'hFFFF_FFFF);
    issue(OP_INC, 3'd4, 3'd1, 3'd0, y, yrd, lat, rdy_low, strobes);
    chk("t2_inc_wrap", y, 32'd0);
    cfg_write(3'd5, 32'd0);
    issue(OP_DEC, 3'd5, 3'd5, 3'd0, y, yrd, lat, rdy_low, strobes);
    chk("t2_dec_wrap", y, 32'hFFFF_FFFF);
    issue(OP_PASSA, 3'd6, 3'd5, 3'd0, y, yrd, lat, rdy_low, strobes);
    chk("t2_r5",       y, 32'hFFFF_FFFF);

    // 4: dependent back-to-back pair
    cfg_write(3'd1, 32'd2);
    issue(OP_ADD, 3'd1, 3'd1, 3'd1, y, yrd, lat, rdy_low, strobes);
    chk("t4_first",     y,            32'd4);
    chk("t4_rdy_low1",  32'(rdy_low), 32'd3);
    issue(OP_ADD, 3'd1, 3'd1, 3'd1, y, yrd, lat, rdy_low, strobes);
    chk("t4_second",    y,            32'd8);
    chk("t4_rdy_low2",  32'(rdy_low), 32'd3);

    // 5a: cfg while busy is ignored, including by the in-flight instruction
    cfg_write(3'd6, 32'h0000_0011);
    instr_valid = 1'b1;
    instr_op    = OP_PASSA;
    instr_rd    = 3'd7;
    instr_rs1   = 3'd6;
    instr_rs2   = 3'd0;
    tick();
    instr_valid = 1'b0;
    cfg_we    = 1'b1;
    cfg_addr  = 3'd6;
    cfg_wdata = 32'hDEAD_BEEF;
    chk("t5_busy", 32'(busy), 32'd1);
    tick();
    tick();
    chk("t5_wb_vld",  32'(res_valid), 32'd1);
    chk("t5_wb_data", res_data,       32'h0000_0011);
    tick();
    cfg_we = 1'b0;
    issue(OP_PASSA, 3'd7, 3'd6, 3'd0, y, yrd, lat, rdy_low, strobes);
    chk("t5_r6_kept", y, 32'h0000_0011);

    // 5b: cfg in the accept cycle is seen by that instruction
    cfg_we    = 1'b1;
    cfg_addr  = 3'd6;
    cfg_wdata = 32'h0000_0077;
    issue(OP_PASSA, 3'd7, 3'd6, 3'd0, y, yrd, lat, rdy_low, strobes);
    chk("t5_same_cycle", y, 32'h0000_0077);

    // 6: reset during EXEC aborts the instruction
    cfg_write(3'd1, 32'd5);
    cfg_write(3'd2, 32'd3);
    cfg_write(3'd3, 32'd9);
    instr_valid = 1'b1;
    instr_op    = OP_ADD;
    instr_rd    = 3'd3;
    instr_rs1   = 3'd1;
    instr_rs2   = 3'd2;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("t6_in_exec", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    chk("t6_no_vld",   32'(res_valid),   32'd0);
    chk("t6_ready",    32'(instr_ready), 32'd1);
    chk("t6_busy",     32'(busy),        32'd0);
    chk("t6_alu_op",   32'(alu_op),      32'd0);
    chk("t6_alu_a",    alu_a,            32'd0);
    chk("t6_alu_b",    alu_b,            32'd0);
    chk("t6_res_rd",   32'(res_rd),      32'd0);
    chk("t6_res_data", res_data,         32'd0);
    reset = 1'b0;
    tick();
    chk("t6_no_vld2",  32'(res_valid),   32'd0);
    issue(OP_PASSA, 3'd6, 3'd3, 3'd0, y, yrd, lat, rdy_low, strobes);
    chk("t6_r3",       y,                32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net in case a handshake never completes.
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule : tb_alu_issue_ctrl
